bch_31_decode_seq: RTL and testbench
====================================

Name: bch_31_decode_seq

Overview:
- Sequential BCH(31,21) double-error-correcting decoder.
- Accepts one received 31-bit codeword over a valid/ready handshake and computes syndromes with the existing bch_31_syndrome block.
- Derives the error-locator polynomial (Peterson, t=2), runs a serial Chien search over all 31 positions, and returns the corrected codeword and message with error status.
- Sits downstream of the channel, paired with bch_31_encoder.

Parameters:
FAST_PATH, 1, 1: zero-error and ELP-detected failures skip the Chien search; 0: every word runs the Chien search (constant latency).

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_codeword valid
in_ready  output  1  block can accept a codeword
in_codeword  input  31  received word; bit i = coefficient of x^i, message in [30:10]
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_codeword  output  31  corrected codeword (raw word if out_fail)
out_msg  output  21  out_codeword[30:10]
out_err_cnt  output  2  number of corrected bits: 0, 1 or 2
out_fail  output  1  uncorrectable word detected
busy  output  1  state != IDLE

Behaviour:
- GF(32) arithmetic:
  - Primitive polynomial x^5+x^2+1, alpha = 5'b00010.
  - Multiply is polynomial product mod p; inverse via 31-entry table.
  - S2 and S4 from bch_31_syndrome are ignored (S2=S1^2 for binary codes).
- Reset (rst_n=0 sampled at edge):
  - state=IDLE; out_valid=0, out_codeword=0, out_err_cnt=0, out_fail=0, busy=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards the in-flight word silently.
- Handshake:
  - in_ready=1 only in IDLE; transfer on in_valid&&in_ready; in_valid outside IDLE is ignored.
  - Output transfer on out_valid&&out_ready.
  - out_* stay stable while out_valid=1 and out_ready=0.
- States, transitions and actions:
  - IDLE: on input transfer, latch cw_q <= in_codeword, go to SYND.
  - SYND: register S1, S3 from bch_31_syndrome(cw_q), go to ELP.
  - ELP: compute and register sigma1, sigma2 and exp_deg:
    - S1=0, S3=0: exp_deg=0.
    - S1=0, S3!=0: fail.
    - S3=S1^3: sigma1=S1, sigma2=0, exp_deg=1.
    - Otherwise: sigma1=S1, sigma2=(S3+S1^3)*inv(S1), exp_deg=2.
    - Load corr_q <= cw_q, r1 <= sigma1, r2 <= sigma2, idx <= 0, roots <= 0.
    - Next state: FAST_PATH=1 and (exp_deg=0 or fail) -> DONE; otherwise -> CHIEN.
  - CHIEN, one position per cycle:
    - If 1^r1^r2==0 and exp_deg!=0: flip corr_q[idx], roots++.
    - Update r1 <= r1*alpha^-1 (alpha^30), r2 <= r2*alpha^-2 (alpha^29), idx++.
    - After idx=30 -> DONE.
  - DONE:
    - Set out_valid=1.
    - If roots!=exp_deg or ELP fail: out_fail=1, out_err_cnt=0, out_codeword=cw_q.
    - Else: out_fail=0, out_err_cnt=exp_deg, out_codeword=corr_q.
    - On output transfer -> IDLE and out_valid=0.
- The CHIEN root test is gated when exp_deg=0 (FAST_PATH=0 zero-error case), so no flips occur.
- Latency, counting the accepting edge as edge 0:
  - out_valid rises at edge 2 on the fast path.
  - out_valid rises at edge 33 for the Chien path (tests at edges 3..33).
  - A new input can be accepted at the edge after the output transfer at the earliest; no overlap.
- Width rules: idx 5 bits, 0..30, never reaches 31; roots saturates at 3.

Decomposition:
- Package bch_31_gf_pkg:
  - Typedef gf32_t (logic [4:0]); constants GF_POLY, ALPHA, ALPHA_INV, ALPHA_INV2.
  - Functions gf_mul, gf_inv (table), gf_cube.
  - State enum dec_state_t {IDLE, SYND, ELP, CHIEN, DONE}.
- Sub-modules:
  - Instantiate the existing bch_31_syndrome.
  - One natural new sub-module: bch_31_chien_cell, holding the r1/r2 registers, constant multipliers and the root test.

Test Plan:
1. Reset, then in_codeword=31'h0 with out_ready=1 -> out_valid at edge 2, out_msg=21'h0, out_err_cnt=0, out_fail=0, in_ready back to 1 the next cycle.
2. Encode 21'h000001 via bch_31_encoder, flip bit 0 -> out_valid at edge 33, out_msg=21'h000001, out_err_cnt=1, out_codeword equals the encoder output.
3. Encode 21'h1FFFFF, flip bits 5 and 30 -> out_msg=21'h1FFFFF, out_err_cnt=2, out_fail=0.
4. Sweep all 31 single-bit and all 465 double-bit error positions on the 21'h0A5A5A codeword -> every result exact against the golden model; 3-bit patterns the model flags uncorrectable -> out_fail=1, out_codeword=raw word.
5. Hold out_ready=0 for 10 cycles after DONE while driving in_valid=1 -> out_* stable, in_ready=0, second word accepted only after the output transfer.
6. Assert rst_n=0 for one cycle at CHIEN idx=15 -> next cycle busy=0, out_valid=0, in_ready=1; a following word decodes correctly. Repeat test 1 with FAST_PATH=0 -> out_valid at edge 33, out_err_cnt=0.

Source files
------------

// File: rtl/bch_31_gf_pkg.sv
// GF(32) arithmetic, field constants and FSM state type shared by the BCH(31,21) decoder.
// Field generated by x^5+x^2+1 with alpha = x.
package bch_31_gf_pkg;

    typedef logic [4:0] gf32_t;

    typedef enum logic [2:0] {IDLE, SYND, ELP, CHIEN, DONE} dec_state_t;

    localparam logic [5:0] GF_POLY    = 6'b100101;
    localparam gf32_t      ALPHA      = 5'b00010;
    localparam gf32_t      ALPHA3     = 5'b01000;
    localparam gf32_t      ALPHA_INV  = 5'b10010;
    localparam gf32_t      ALPHA_INV2 = 5'b01001;

    function automatic gf32_t gf_mul(input gf32_t a, input gf32_t b);
        logic [8:0] p;
        p = '0;
        for (int i = 0; i < 5; i++)
            if (b[i]) p = p ^ ({4'b0, a} << i);
        for (int i = 8; i >= 5; i--)
            if (p[i]) p = p ^ ({3'b0, GF_POLY} << (i - 5));
        return p[4:0];
    endfunction

    // inv(alpha^k) = alpha^(31-k); zero has no inverse and maps to zero
    function automatic gf32_t gf_inv(input gf32_t a);
        gf32_t r;
        case (a)
            5'd1:  r = 5'd1;   5'd2:  r = 5'd18;  5'd3:  r = 5'd28;  5'd4:  r = 5'd9;
            5'd5:  r = 5'd23;  5'd6:  r = 5'd14;  5'd7:  r = 5'd12;  5'd8:  r = 5'd22;
            5'd9:  r = 5'd4;   5'd10: r = 5'd25;  5'd11: r = 5'd16;  5'd12: r = 5'd7;
            5'd13: r = 5'd15;  5'd14: r = 5'd6;   5'd15: r = 5'd13;  5'd16: r = 5'd11;
            5'd17: r = 5'd24;  5'd18: r = 5'd2;   5'd19: r = 5'd29;  5'd20: r = 5'd30;
            5'd21: r = 5'd26;  5'd22: r = 5'd8;   5'd23: r = 5'd5;   5'd24: r = 5'd17;
            5'd25: r = 5'd10;  5'd26: r = 5'd21;  5'd27: r = 5'd31;  5'd28: r = 5'd3;
            5'd29: r = 5'd19;  5'd30: r = 5'd20;  5'd31: r = 5'd27;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    function automatic gf32_t gf_cube(input gf32_t a);
        return gf_mul(gf_mul(a, a), a);
    endfunction

endpackage

// File: rtl/bch_31_chien_cell.sv
// Chien search cell: holds the scaled locator terms and flags a root at the current position.
module bch_31_chien_cell
    import bch_31_gf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       step_i,
    input  logic [4:0] sigma1_i,
    input  logic [4:0] sigma2_i,
    output logic       root_o
);

    gf32_t r1_q, r1_d;
    gf32_t r2_q, r2_d;

    always_comb begin
        r1_d = r1_q;
        r2_d = r2_q;
        if (load_i) begin
            r1_d = sigma1_i;
            r2_d = sigma2_i;
        end else if (step_i) begin
            r1_d = gf_mul(r1_q, ALPHA_INV);
            r2_d = gf_mul(r2_q, ALPHA_INV2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_q <= '0;
            r2_q <= '0;
        end else begin
            r1_q <= r1_d;
            r2_q <= r2_d;
        end
    end

    assign root_o = ((5'd1 ^ r1_q ^ r2_q) == 5'd0);

endmodule

// File: rtl/bch_31_syndrome.sv
// Combinational syndromes S1..S4 of a received 31-bit word, evaluated by Horner's rule.
module bch_31_syndrome
    import bch_31_gf_pkg::*;
(
    input  logic [30:0] cw_i,
    output logic [4:0]  s1_o,
    output logic [4:0]  s2_o,
    output logic [4:0]  s3_o,
    output logic [4:0]  s4_o
);

    always_comb begin
        s1_o = '0;
        s3_o = '0;
        for (int i = 30; i >= 0; i--) begin
            s1_o = gf_mul(s1_o, ALPHA)  ^ {4'b0, cw_i[i]};
            s3_o = gf_mul(s3_o, ALPHA3) ^ {4'b0, cw_i[i]};
        end
        s2_o = gf_mul(s1_o, s1_o);
        s4_o = gf_mul(s2_o, s2_o);
    end

endmodule

// File: rtl/bch_31_decode_seq.sv
// Sequential BCH(31,21) t=2 decoder: IDLE accept | SYND latch S1,S3 | ELP Peterson locator
// | CHIEN one position per cycle | DONE hold result until consumed.
module bch_31_decode_seq
    import bch_31_gf_pkg::*;
#(
    parameter int FAST_PATH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] in_codeword,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] out_codeword,
    output logic [20:0] out_msg,
    output logic [1:0]  out_err_cnt,
    output logic        out_fail,
    output logic        busy
);

    dec_state_t  state_q, state_d;
    logic [30:0] cw_q, cw_d;
    logic [30:0] corr_q, corr_d;
    gf32_t       s1_q, s1_d, s3_q, s3_d;
    logic [1:0]  exp_deg_q, exp_deg_d;
    logic        fail_q, fail_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  roots_q, roots_d;

    gf32_t       syn_s1, syn_s3, syn_s2_unused, syn_s4_unused;
    gf32_t       s1_cube, elp_sigma1, elp_sigma2;
    logic [1:0]  elp_deg;
    logic        elp_fail;
    logic        chien_load, chien_step, chien_root;
    logic        bad;

    bch_31_syndrome u_syndrome (
        .cw_i (cw_q),
        .s1_o (syn_s1),
        .s2_o (syn_s2_unused),
        .s3_o (syn_s3),
        .s4_o (syn_s4_unused)
    );

    bch_31_chien_cell u_chien (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (chien_load),
        .step_i   (chien_step),
        .sigma1_i (elp_sigma1),
        .sigma2_i (elp_sigma2),
        .root_o   (chien_root)
    );

    always_comb begin
        s1_cube    = gf_cube(s1_q);
        elp_sigma1 = '0;
        elp_sigma2 = '0;
        elp_deg    = 2'd0;
        elp_fail   = 1'b0;
        if (s1_q == '0) begin
            elp_fail = (s3_q != '0);
        end else if (s3_q == s1_cube) begin
            elp_sigma1 = s1_q;
            elp_deg    = 2'd1;
        end else begin
            elp_sigma1 = s1_q;
            elp_sigma2 = gf_mul(s3_q ^ s1_cube, gf_inv(s1_q));
            elp_deg    = 2'd2;
        end
    end

    always_comb begin
        state_d    = state_q;
        cw_d       = cw_q;
        corr_d     = corr_q;
        s1_d       = s1_q;
        s3_d       = s3_q;
        exp_deg_d  = exp_deg_q;
        fail_d     = fail_q;
        idx_d      = idx_q;
        roots_d    = roots_q;
        chien_load = 1'b0;
        chien_step = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                cw_d    = in_codeword;
                state_d = SYND;
            end
            SYND: begin
                s1_d    = syn_s1;
                s3_d    = syn_s3;
                state_d = ELP;
            end
            ELP: begin
                exp_deg_d  = elp_deg;
                fail_d     = elp_fail;
                corr_d     = cw_q;
                idx_d      = 5'd0;
                roots_d    = 2'd0;
                chien_load = 1'b1;
                if (FAST_PATH != 0 && (elp_deg == 2'd0 || elp_fail)) state_d = DONE;
                else                                                  state_d = CHIEN;
            end
            CHIEN: begin
                chien_step = 1'b1;
                // exp_deg=0 words still walk all positions but must never be altered
                if (chien_root && exp_deg_q != 2'd0) begin
                    corr_d[idx_q] = ~corr_q[idx_q];
                    if (roots_q != 2'd3) roots_d = roots_q + 2'd1;
                end
                if (idx_q == 5'd30) state_d = DONE;
                else                idx_d   = idx_q + 5'd1;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cw_q      <= '0;
            corr_q    <= '0;
            s1_q      <= '0;
            s3_q      <= '0;
            exp_deg_q <= '0;
            fail_q    <= 1'b0;
            idx_q     <= '0;
            roots_q   <= '0;
        end else begin
            state_q   <= state_d;
            cw_q      <= cw_d;
            corr_q    <= corr_d;
            s1_q      <= s1_d;
            s3_q      <= s3_d;
            exp_deg_q <= exp_deg_d;
            fail_q    <= fail_d;
            idx_q     <= idx_d;
            roots_q   <= roots_d;
        end
    end

    assign bad          = fail_q || (roots_q != exp_deg_q);
    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_fail     = out_valid && bad;
    assign out_err_cnt  = (out_valid && !bad) ? exp_deg_q : 2'd0;
    assign out_codeword = out_valid ? (bad ? cw_q : corr_q) : 31'd0;
    assign out_msg      = out_codeword[30:10];

endmodule

// File: tb/tb_bch_31_decode_seq.sv
// Bench for bch_31_decode_seq: brute-force nearest-codeword model, FAST_PATH=1 and FAST_PATH=0 instances.
module tb_bch_31_decode_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_a, in_valid_b, out_ready;
    logic [30:0] in_codeword;

    logic        a_in_ready, a_out_valid, a_out_fail, a_busy;
    logic [30:0] a_out_codeword;
    logic [20:0] a_out_msg;
    logic [1:0]  a_out_err_cnt;
    logic        b_in_ready, b_out_valid, b_out_fail, b_busy;
    logic [30:0] b_out_codeword;
    logic [20:0] b_out_msg;
    logic [1:0]  b_out_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] pow_t [31];

    always #5 clk = ~clk;

    bch_31_decode_seq #(.FAST_PATH(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(a_in_ready),
        .in_codeword(in_codeword), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_codeword(a_out_codeword), .out_msg(a_out_msg), .out_err_cnt(a_out_err_cnt),
        .out_fail(a_out_fail), .busy(a_busy));

    bch_31_decode_seq #(.FAST_PATH(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(b_in_ready),
        .in_codeword(in_codeword), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_codeword(b_out_codeword), .out_msg(b_out_msg), .out_err_cnt(b_out_err_cnt),
        .out_fail(b_out_fail), .busy(b_busy));

    // ---------------- reference model ----------------
    function automatic logic [30:0] encode(input logic [20:0] msg);
        logic [30:0] rem;
        logic [30:0] g;
        g   = 31'h769;
        rem = {msg, 10'b0};
        for (int i = 30; i >= 10; i--)
            if (rem[i]) rem = rem ^ (g << (i - 10));
        return {msg, rem[9:0]};
    endfunction

    function automatic void model_syn(input logic [30:0] r, output logic [4:0] s1, output logic [4:0] s3);
        s1 = '0;
        s3 = '0;
        for (int i = 0; i < 31; i++)
            if (r[i]) begin
                s1 = s1 ^ pow_t[i];
                s3 = s3 ^ pow_t[(3 * i) % 31];
            end
    endfunction

    // Nearest codeword within distance 2, found by matching syndromes of every weight<=2 pattern
    function automatic void model_decode(input logic [30:0] r, output logic fail,
                                         output logic [1:0] cnt, output logic [30:0] cw);
        logic [4:0] s1, s3;
        model_syn(r, s1, s3);
        fail = 1'b0;
        cnt  = 2'd0;
        cw   = r;
        if (s1 == 0 && s3 == 0) return;
        for (int i = 0; i < 31; i++)
            if (pow_t[i] == s1 && pow_t[(3 * i) % 31] == s3) begin
                cnt = 2'd1;
                cw  = r ^ (31'd1 << i);
                return;
            end
        for (int i = 0; i < 31; i++)
            for (int j = i + 1; j < 31; j++)
                if ((pow_t[i] ^ pow_t[j]) == s1 &&
                    (pow_t[(3 * i) % 31] ^ pow_t[(3 * j) % 31]) == s3) begin
                    cnt = 2'd2;
                    cw  = r ^ (31'd1 << i) ^ (31'd1 << j);
                    return;
                end
        fail = 1'b1;
    endfunction

    // Fast-path instance skips the search exactly when S1 is zero
    function automatic int model_lat(input int which, input logic [30:0] r);
        logic [4:0] s1, s3;
        model_syn(r, s1, s3);
        if (which == 0 && s1 == 0) return 2;
        return 33;
    endfunction

    // ---------------- stimulus ----------------
    task automatic run_word(input int which, input logic [30:0] cw, output int lat,
                            output logic [30:0] ocw, output logic [1:0] ocnt,
                            output logic ofail, output logic [20:0] omsg);
        int n;
        out_ready   = 1'b1;
        in_codeword = cw;
        if (which == 0) in_valid_a = 1'b1; else in_valid_b = 1'b1;
        n = 0;
        while (((which == 0) ? a_in_ready : b_in_ready) !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            in_valid_a = 1'b0; in_valid_b = 1'b0;
            lat = -1; ocw = 'x; ocnt = 'x; ofail = 1'bx; omsg = 'x;
            return;
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        lat = 0;
        while (((which == 0) ? a_out_valid : b_out_valid) !== 1'b1 && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        ocw   = (which == 0) ? a_out_codeword : b_out_codeword;
        ocnt  = (which == 0) ? a_out_err_cnt  : b_out_err_cnt;
        ofail = (which == 0) ? a_out_fail     : b_out_fail;
        omsg  = (which == 0) ? a_out_msg      : b_out_msg;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready = 1'b1; in_codeword = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
        n_checks++; if (a_out_codeword !== 31'd0) begin n_fail++; $display("FAIL reset_out_codeword got %h want 0", a_out_codeword); end
        n_checks++; if (a_out_err_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", a_out_err_cnt); end
        n_checks++; if (a_out_fail !== 1'b0) begin n_fail++; $display("FAIL reset_out_fail got %b want 0", a_out_fail); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", a_busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    endtask

    task automatic test_zero_word();
        int lat; logic [30:0] ocw; logic [1:0] ocnt; logic ofail; logic [20:0] omsg;
        run_word(0, 31'd0, lat, ocw, ocnt, ofail, omsg);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL zero_latency got %0d want 2", lat); end
        n_checks++; if (omsg !== 21'd0) begin n_fail++; $display("FAIL zero_msg got %h want 0", omsg); end
        n_checks++; if (ocnt !== 2'd0) begin n_fail++; $display("FAIL zero_err_cnt got %0d want 0", ocnt); end
        n_checks++; if (ofail !== 1'b0) begin n_fail++; $display("FAIL zero_fail got %b want 0", ofail); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_in_ready_after got %b want 1", a_in_ready); end
    endtask

    task automatic test_single_double();
        int lat; logic [30:0] ocw, enc; logic [1:0] ocnt; logic ofail; logic [20:0] omsg;
        enc = encode(21'h000001);
        run_word(0, enc ^ 31'd1, lat, ocw, ocnt, ofail, omsg);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL single_latency got %0d want 33", lat); end
        n_checks++; if (omsg !== 21'h000001) begin n_fail++; $display("FAIL single_msg got %h want 000001", omsg); end
        n_checks++; if (ocnt !== 2'd1) begin n_fail++; $display("FAIL single_err_cnt got %0d want 1", ocnt); end
        n_checks++; if (ocw !== enc) begin n_fail++; $display("FAIL single_codeword got %h want %h", ocw, enc); end
        enc = encode(21'h1FFFFF);
        run_word(0, enc ^ (31'd1 << 5) ^ (31'd1 << 30), lat, ocw, ocnt, ofail, omsg);
        n_checks++; if (omsg !== 21'h1FFFFF) begin n_fail++; $display("FAIL double_msg got %h want 1fffff", omsg); end
        n_checks++; if (ocnt !== 2'd2) begin n_fail++; $display("FAIL double_err_cnt got %0d want 2", ocnt); end
        n_checks++; if (ofail !== 1'b0) begin n_fail++; $display("FAIL double_fail got %b want 0", ofail); end
    endtask

    task automatic test_sweep();
        logic [30:0] words[$];
        logic [30:0] base, w, ocw, ecw;
        logic [1:0]  ocnt, ecnt;
        logic        ofail, efail;
        logic [20:0] omsg;
        int          lat, elat;
        base = encode(21'h0A5A5A);
        for (int i = 0; i < 31; i++) words.push_back(base ^ (31'd1 << i));
        for (int i = 0; i < 31; i++)
            for (int j = i + 1; j < 31; j++)
                words.push_back(base ^ (31'd1 << i) ^ (31'd1 << j));
        words.push_back(base ^ 31'd1 ^ 31'd2 ^ (31'd1 << 18));
        for (int k = 0; k < 30; k++) begin
            int p0, p1, p2;
            p0 = int'($urandom_range(30, 0));
            p1 = int'($urandom_range(30, 0));
            p2 = int'($urandom_range(30, 0));
            words.push_back(base ^ (31'd1 << p0) ^ (31'd1 << p1) ^ (31'd1 << p2));
        end
        for (int k = 0; k < 30; k++) begin
            logic [20:0] m;
            int          nerr;
            m    = 21'($urandom);
            nerr = int'($urandom_range(3, 0));
            w    = encode(m);
            for (int e = 0; e < nerr; e++) w = w ^ (31'd1 << $urandom_range(30, 0));
            words.push_back(w);
        end
        foreach (words[k]) begin
            w = words[k];
            run_word(0, w, lat, ocw, ocnt, ofail, omsg);
            model_decode(w, efail, ecnt, ecw);
            elat = model_lat(0, w);
            n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL sweep_latency word %h got %0d want %0d", w, lat, elat); end
            n_checks++; if (ocw !== ecw) begin n_fail++; $display("FAIL sweep_codeword word %h got %h want %h", w, ocw, ecw); end
            n_checks++; if (ocnt !== (efail ? 2'd0 : ecnt)) begin n_fail++; $display("FAIL sweep_err_cnt word %h got %0d want %0d", w, ocnt, ecnt); end
            n_checks++; if (ofail !== efail) begin n_fail++; $display("FAIL sweep_fail word %h got %b want %b", w, ofail, efail); end
            n_checks++; if (omsg !== ecw[30:10]) begin n_fail++; $display("FAIL sweep_msg word %h got %h want %h", w, omsg, ecw[30:10]); end
        end
    endtask

    task automatic test_back_to_back_hold();
        logic [30:0] w1, w2, ecw, ocw;
        logic [1:0]  ecnt, ocnt;
        logic        efail, ofail;
        logic [20:0] omsg;
        int          n, lat;
        w1 = encode(21'($urandom)) ^ (31'd1 << 7);
        w2 = encode(21'($urandom)) ^ (31'd1 << 2) ^ (31'd1 << 25);
        out_ready   = 1'b0;
        in_codeword = w1;
        in_valid_a  = 1'b1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready_before got %b want 1", a_in_ready); end
        @(posedge clk); #1;
        in_codeword = w2;
        n = 0;
        while (a_out_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
        n_checks++; if (n !== 33) begin n_fail++; $display("FAIL hold_latency got %0d want 33", n); end
        model_decode(w1, efail, ecnt, ecw);
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (a_out_valid !== 1'b1 || a_out_codeword !== ecw || a_out_err_cnt !== ecnt || a_out_fail !== efail)
                begin n_fail++; $display("FAIL hold_stable cycle %0d got v=%b cw=%h cnt=%0d want cw=%h cnt=%0d", c, a_out_valid, a_out_codeword, a_out_err_cnt, ecw, ecnt); end
            n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cycle %0d got %b want 0", c, a_in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release got v=%b rdy=%b want 0 1", a_out_valid, a_in_ready); end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL second_accept busy got %b want 1", a_busy); end
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
        ocw = a_out_codeword; ocnt = a_out_err_cnt; ofail = a_out_fail; omsg = a_out_msg;
        model_decode(w2, efail, ecnt, ecw);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL second_latency got %0d want 33", lat); end
        n_checks++; if (ocw !== ecw || ocnt !== ecnt || ofail !== efail || omsg !== ecw[30:10])
            begin n_fail++; $display("FAIL second_result got %h/%0d/%b want %h/%0d/%b", ocw, ocnt, ofail, ecw, ecnt, efail); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_chien();
        logic [30:0] w, ecw, ocw;
        logic [1:0]  ecnt, ocnt;
        logic        efail, ofail;
        logic [20:0] omsg;
        int          lat;
        w = encode(21'h123456) ^ (31'd1 << 3) ^ (31'd1 << 20);
        out_ready   = 1'b1;
        in_codeword = w;
        in_valid_a  = 1'b1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_before got %b want 1", a_in_ready); end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        n_checks++; if (a_busy !== 1'b1 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_in_chien got busy=%b v=%b want 1 0", a_busy, a_out_valid); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", a_busy); end
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", a_out_valid); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", a_in_ready); end
        rst_n = 1'b1;
        w = encode(21'h0F0F0F) ^ (31'd1 << 11) ^ (31'd1 << 29);
        run_word(0, w, lat, ocw, ocnt, ofail, omsg);
        model_decode(w, efail, ecnt, ecw);
        n_checks++; if (lat !== 33 || ocw !== ecw || ocnt !== ecnt || ofail !== efail)
            begin n_fail++; $display("FAIL midrst_follow got lat=%0d %h/%0d/%b want %h/%0d/%b", lat, ocw, ocnt, ofail, ecw, ecnt, efail); end
    endtask

    task automatic test_constant_latency();
        logic [30:0] w, ecw, ocw;
        logic [1:0]  ecnt, ocnt;
        logic        efail, ofail;
        logic [20:0] omsg;
        int          lat;
        run_word(1, 31'd0, lat, ocw, ocnt, ofail, omsg);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL nofast_zero_latency got %0d want 33", lat); end
        n_checks++; if (ocnt !== 2'd0 || ofail !== 1'b0 || ocw !== 31'd0) begin n_fail++; $display("FAIL nofast_zero_result got %h/%0d/%b want 0/0/0", ocw, ocnt, ofail); end
        for (int k = 0; k < 8; k++) begin
            w = encode(21'($urandom));
            if (k == 0) w = w ^ 31'd1 ^ 31'd2 ^ (31'd1 << 18);
            else for (int e = 0; e < k % 4; e++) w = w ^ (31'd1 << $urandom_range(30, 0));
            run_word(1, w, lat, ocw, ocnt, ofail, omsg);
            model_decode(w, efail, ecnt, ecw);
            n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL nofast_latency word %h got %0d want 33", w, lat); end
            n_checks++; if (ocw !== ecw || ocnt !== (efail ? 2'd0 : ecnt) || ofail !== efail)
                begin n_fail++; $display("FAIL nofast_result word %h got %h/%0d/%b want %h/%0d/%b", w, ocw, ocnt, ofail, ecw, ecnt, efail); end
        end
    endtask

    initial begin
        logic [5:0] v;
        v = 6'd1;
        for (int i = 0; i < 31; i++) begin
            pow_t[i] = v[4:0];
            v = v << 1;
            if (v[5]) v = v ^ 6'h25;
        end
        test_reset();
        test_zero_word();
        test_single_double();
        test_sweep();
        test_back_to_back_hold();
        test_reset_mid_chien();
        test_constant_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
